// File: rtl/lzma_stream_arbiter.sv
// Packet-level round-robin arbiter merging N byte-wide AXI-stream LZMA cores onto one
// output, optionally prefixing each granted packet with the 13-byte LZMA header.
module lzma_stream_arbiter #(
  parameter int N         = 4,
  parameter bit HEADER_EN = 1'b1,
  localparam int IW       = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_tvalid,
  output logic [N-1:0]    i_tready,
  input  logic [8*N-1:0]  i_tdata,
  input  logic [N-1:0]    i_tlast,
  output logic            o_tvalid,
  input  logic            o_tready,
  output logic [7:0]      o_tdata,
  output logic            o_tlast,
  output logic [IW-1:0]   o_grant,
  output logic            o_busy,
  output logic [15:0]     o_pkt_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic [IW-1:0] r_grant, w_grant_nxt;
  logic [15:0]   r_pkt_cnt, w_pkt_cnt_nxt;

  logic          w_req_found;
  logic [IW-1:0] w_req_ch;
  logic [IW-1:0] w_cand [N];
  logic [7:0]    w_ch_data [N];

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_byte = 8'h5E;
      4'd1:    hdr_byte = 8'h00;
      4'd2:    hdr_byte = 8'h00;
      4'd3:    hdr_byte = 8'h02;
      4'd4:    hdr_byte = 8'h00;
      default: hdr_byte = 8'hFF;
    endcase
  endfunction

  // Candidate k is the k-th channel after the last grant, so the search wraps naturally.
  for (genvar k = 0; k < N; k++) begin : g_ch
    assign w_cand[k]    = IW'((int'(r_grant) + k + 1) % N);
    assign w_ch_data[k] = i_tdata[8*k +: 8];
  end

  always_comb begin
    w_req_found = 1'b0;
    w_req_ch    = r_grant;
    for (int k = 0; k < N; k++) begin
      if (!w_req_found && i_tvalid[w_cand[k]]) begin
        w_req_found = 1'b1;
        w_req_ch    = w_cand[k];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_grant_nxt   = r_grant;
    w_pkt_cnt_nxt = r_pkt_cnt;
    o_tvalid      = 1'b0;
    o_tdata       = 8'h00;
    o_tlast       = 1'b0;
    i_tready      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req_found) begin
          w_grant_nxt = w_req_ch;
          w_state_nxt = HEADER_EN ? S_HEADER : S_BODY;
        end
      end
      S_HEADER: begin
        o_tvalid = 1'b1;
        o_tdata  = hdr_byte(r_idx);
        if (o_tready) begin
          if (r_idx == 4'd12) begin
            w_idx_nxt   = 4'd0;
            w_state_nxt = S_BODY;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      S_BODY: begin
        // Zero-latency pass-through; the grant is held until the tlast handshake.
        o_tvalid          = i_tvalid[r_grant];
        o_tdata           = w_ch_data[r_grant];
        o_tlast           = i_tlast[r_grant];
        i_tready[r_grant] = o_tready;
        if (o_tready && i_tvalid[r_grant] && i_tlast[r_grant]) begin
          w_state_nxt   = S_IDLE;
          w_pkt_cnt_nxt = r_pkt_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 4'd0;
      r_grant   <= IW'(N - 1);
      r_pkt_cnt <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_grant   <= w_grant_nxt;
      r_pkt_cnt <= w_pkt_cnt_nxt;
    end
  end

  assign o_grant   = r_grant;
  assign o_busy    = (r_state != S_IDLE);
  assign o_pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_lzma_stream_arbiter.sv
// Bench for lzma_stream_arbiter: queued channel sources, a packet-level round-robin
// model of the merged stream, and scenario tasks run in sequence.
module tb_lzma_stream_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   i_tvalid, i_tready, i_tlast;
  logic [8*N-1:0] i_tdata;
  logic           o_tvalid, o_tready, o_tlast, o_busy;
  logic [7:0]     o_tdata;
  logic [1:0]     o_grant;
  logic [15:0]    o_pkt_cnt;

  logic [N-1:0]   n_i_tvalid, n_i_tready, n_i_tlast;
  logic [8*N-1:0] n_i_tdata;
  logic           n_o_tvalid, n_o_tready, n_o_tlast, n_o_busy;
  logic [7:0]     n_o_tdata;
  logic [1:0]     n_o_grant;
  logic [15:0]    n_o_pkt_cnt;

  lzma_stream_arbiter #(.N(N), .HEADER_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
    .i_tlast(i_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_grant(o_grant), .o_busy(o_busy), .o_pkt_cnt(o_pkt_cnt));

  lzma_stream_arbiter #(.N(N), .HEADER_EN(1'b0)) dut_nh (
    .clk(clk), .rst(rst), .i_tvalid(n_i_tvalid), .i_tready(n_i_tready), .i_tdata(n_i_tdata),
    .i_tlast(n_i_tlast), .o_tvalid(n_o_tvalid), .o_tready(n_o_tready), .o_tdata(n_o_tdata),
    .o_tlast(n_o_tlast), .o_grant(n_o_grant), .o_busy(n_o_busy), .o_pkt_cnt(n_o_pkt_cnt));

  localparam logic [7:0] HDR [13] = '{8'h5E, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF,
                                      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  int tests = 0, fails = 0;
  logic [7:0] ch_mem [N][64];
  bit         ch_lst [N][64];
  int         ch_ptr [N], ch_len [N];
  logic [8:0] obs_q[$], exp_q[$], gnt_obs[$], gnt_exp[$];
  int m_grant, m_pkts;
  bit throttle, stall_pend, gap_pend, prev_busy;
  bit hs_ch [N];
  logic [8:0] stall_val;

  function automatic int first_diff(input logic [8:0] a[$], input logic [8:0] b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (ch_ptr[c] < ch_len[c]) begin
        i_tvalid[c] = 1'b1; i_tdata[8*c +: 8] = ch_mem[c][ch_ptr[c]]; i_tlast[c] = ch_lst[c][ch_ptr[c]];
      end else begin
        i_tvalid[c] = 1'b0; i_tdata[8*c +: 8] = 8'h00; i_tlast[c] = 1'b0;
      end
    end
  endtask

  task automatic clear_chans();
    for (int c = 0; c < N; c++) begin ch_ptr[c] = 0; ch_len[c] = 0; hs_ch[c] = 0; end
    obs_q.delete(); exp_q.delete(); gnt_obs.delete(); gnt_exp.delete();
  endtask

  task automatic add_pkt(input int c, input int len);
    for (int i = 0; i < len; i++) begin
      ch_mem[c][ch_len[c]] = 8'($urandom);
      ch_lst[c][ch_len[c]] = (i == len - 1);
      ch_len[c]++;
    end
  endtask

  // Reference: packet-level round robin over channels that still hold packets.
  task automatic build_expected(input bit hdr_en);
    int p [N];
    bit more = 1;
    for (int c = 0; c < N; c++) p[c] = ch_ptr[c];
    while (more) begin
      more = 0;
      for (int k = 1; k <= N && !more; k++) begin
        int c = (m_grant + k) % N;
        if (p[c] < ch_len[c]) begin
          bit done = 0;
          more = 1;
          m_grant = c;
          gnt_exp.push_back(9'(c));
          if (hdr_en) for (int i = 0; i < 13; i++) exp_q.push_back({1'b0, HDR[i]});
          while (!done && p[c] < ch_len[c]) begin
            exp_q.push_back({ch_lst[c][p[c]], ch_mem[c][p[c]]});
            done = ch_lst[c][p[c]];
            p[c]++;
          end
          m_pkts++;
        end
      end
    end
  endtask

  task automatic sample();
    logic [N-1:0] mask;
    mask = o_busy ? (4'(1) << o_grant) : 4'(0);
    tests++;
    if ((i_tready & ~mask) !== 4'(0)) begin
      fails++;
      $display("FAIL tready_mask: i_tready=%b busy=%b grant=%0d", i_tready, o_busy, o_grant);
    end
    if (gap_pend) begin
      tests++;
      if (o_tvalid !== 1'b0 || o_busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_gap: o_tvalid=%b o_busy=%b, required 0 0", o_tvalid, o_busy);
      end
      gap_pend = 0;
    end
    if (stall_pend && o_tvalid) begin
      tests++;
      if ({o_tlast, o_tdata} !== stall_val) begin
        fails++;
        $display("FAIL stall_stable: got %h held %h", {o_tlast, o_tdata}, stall_val);
      end
    end
    stall_pend = 0;
    if (o_busy && !prev_busy) gnt_obs.push_back(9'(o_grant));
    prev_busy = o_busy;
    if (o_tvalid && o_tready) begin
      obs_q.push_back({o_tlast, o_tdata});
      if (o_tlast) gap_pend = 1;
    end
    if (o_tvalid && !o_tready) begin stall_pend = 1; stall_val = {o_tlast, o_tdata}; end
    for (int c = 0; c < N; c++) hs_ch[c] = i_tvalid[c] && i_tready[c];
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) if (hs_ch[c]) ch_ptr[c]++;
    o_tready = throttle ? (($urandom % 4) != 0) : 1'b1;
    drive();
  endtask

  task automatic run(input int budget, input string name);
    int n = 0;
    bit all_done = 0;
    while (n < budget && !all_done) begin
      cyc(); n++;
      all_done = !o_busy;
      for (int c = 0; c < N; c++) if (ch_ptr[c] < ch_len[c]) all_done = 0;
    end
    cyc();
    tests++;
    if (!all_done) begin
      fails++;
      $display("FAIL %s_timeout: %0d cycles used, budget %0d", name, n, budget);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_grant = N - 1; m_pkts = 0;
    prev_busy = 0; gap_pend = 0; stall_pend = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; throttle = 0; o_tready = 1'b1;
    n_i_tvalid = '0; n_i_tdata = '0; n_i_tlast = '0; n_o_tready = 1'b0;
    clear_chans(); drive();
    @(negedge clk); @(negedge clk);
    tests++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b need 0", o_tvalid); end
    tests++; if (i_tready !== 4'b0) begin fails++; $display("FAIL rst_tready: got %b need 0000", i_tready); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b need 0", o_busy); end
    tests++; if (o_grant !== 2'd3) begin fails++; $display("FAIL rst_grant: got %0d need 3", o_grant); end
    tests++; if (o_pkt_cnt !== 16'd0) begin fails++; $display("FAIL rst_pkt_cnt: got %0d need 0", o_pkt_cnt); end
    rst = 1'b0;
    m_grant = N - 1; m_pkts = 0; prev_busy = 0; gap_pend = 0; stall_pend = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cyc();
    tests++;
    if (o_busy !== 1'b0 || o_tvalid !== 1'b0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL rst_idle: busy=%b tvalid=%b bytes=%0d, need 0 0 0", o_busy, o_tvalid, obs_q.size());
    end
  endtask

  task automatic test_single_packet();
    int d;
    clear_chans();
    ch_mem[2][0] = 8'hAA; ch_lst[2][0] = 0;
    ch_mem[2][1] = 8'hBB; ch_lst[2][1] = 0;
    ch_mem[2][2] = 8'hCC; ch_lst[2][2] = 1;
    ch_len[2] = 3;
    for (int i = 0; i < 13; i++) exp_q.push_back({1'b0, HDR[i]});
    exp_q.push_back(9'h0AA); exp_q.push_back(9'h0BB); exp_q.push_back(9'h1CC);
    m_grant = 2; m_pkts = 1;
    drive();
    run(100, "single");
    d = first_diff(obs_q, exp_q);
    tests++; if (d != -1) begin fails++; $display("FAIL single_stream: first diff at %0d, got %0d bytes need 16", d, obs_q.size()); end
    tests++; if (o_pkt_cnt !== 16'd1) begin fails++; $display("FAIL single_pkt_cnt: got %0d need 1", o_pkt_cnt); end
    tests++; if (o_grant !== 2'd2) begin fails++; $display("FAIL single_grant: got %0d need 2", o_grant); end
  endtask

  task automatic test_round_robin();
    int d;
    int want [5] = '{0, 1, 2, 3, 0};
    bit ok;
    reset_dut();
    clear_chans();
    for (int r = 0; r < 2; r++) for (int c = 0; c < N; c++) add_pkt(c, 2);
    build_expected(1'b1);
    drive();
    run(400, "rr");
    d = first_diff(obs_q, exp_q);
    tests++; if (d != -1) begin fails++; $display("FAIL rr_stream: first diff at %0d, got %0d bytes need %0d", d, obs_q.size(), exp_q.size()); end
    d = first_diff(gnt_obs, gnt_exp);
    tests++; if (d != -1) begin fails++; $display("FAIL rr_grant_model: first diff at %0d", d); end
    ok = gnt_obs.size() >= 5;
    for (int i = 0; i < 5 && ok; i++) ok = (gnt_obs[i] == 9'(want[i]));
    tests++; if (!ok) begin fails++; $display("FAIL rr_grant_order: first grants not 0,1,2,3,0 (%0d recorded)", gnt_obs.size()); end
    tests++; if (o_pkt_cnt !== 16'(m_pkts)) begin fails++; $display("FAIL rr_pkt_cnt: got %0d need %0d", o_pkt_cnt, m_pkts); end
  endtask

  task automatic test_throttle();
    logic [8:0] free_q[$];
    int d;
    reset_dut();
    clear_chans();
    for (int c = 0; c < N; c++) begin
      int np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(1, 6));
    end
    build_expected(1'b1);
    throttle = 0;
    drive();
    run(1000, "free");
    free_q = obs_q;
    d = first_diff(obs_q, exp_q);
    tests++; if (d != -1) begin fails++; $display("FAIL free_stream: first diff at %0d, got %0d need %0d", d, obs_q.size(), exp_q.size()); end
    reset_dut();
    for (int c = 0; c < N; c++) ch_ptr[c] = 0;
    obs_q.delete(); exp_q.delete(); gnt_obs.delete(); gnt_exp.delete();
    build_expected(1'b1);
    throttle = 1;
    drive();
    run(3000, "thr");
    throttle = 0;
    d = first_diff(obs_q, exp_q);
    tests++; if (d != -1) begin fails++; $display("FAIL thr_stream: first diff at %0d, got %0d need %0d", d, obs_q.size(), exp_q.size()); end
    d = first_diff(obs_q, free_q);
    tests++; if (d != -1) begin fails++; $display("FAIL thr_vs_free: first diff at %0d", d); end
    tests++; if (o_pkt_cnt !== 16'(m_pkts)) begin fails++; $display("FAIL thr_pkt_cnt: got %0d need %0d", o_pkt_cnt, m_pkts); end
  endtask

  task automatic test_noheader();
    logic [15:0] cnt0;
    @(negedge clk);
    cnt0 = n_o_pkt_cnt;
    @(posedge clk); #1;
    n_o_tready = 1'b1;
    n_i_tvalid = 4'b0010; n_i_tdata[15:8] = 8'h7E; n_i_tlast = 4'b0010;
    @(negedge clk);
    tests++; if (n_o_tvalid !== 1'b0) begin fails++; $display("FAIL nh_pre_edge: o_tvalid=%b need 0", n_o_tvalid); end
    @(negedge clk);
    tests++;
    if ({n_o_tvalid, n_o_tlast, n_o_tdata} !== {1'b1, 1'b1, 8'h7E}) begin
      fails++;
      $display("FAIL nh_byte: got v=%b l=%b d=%h need 1 1 7e", n_o_tvalid, n_o_tlast, n_o_tdata);
    end
    tests++; if (n_o_grant !== 2'd1) begin fails++; $display("FAIL nh_grant: got %0d need 1", n_o_grant); end
    tests++; if (n_i_tready !== 4'b0010) begin fails++; $display("FAIL nh_tready: got %b need 0010", n_i_tready); end
    @(posedge clk); #1;
    n_i_tvalid = '0; n_i_tlast = '0;
    @(negedge clk);
    tests++; if (n_o_pkt_cnt !== cnt0 + 16'd1) begin fails++; $display("FAIL nh_pkt_cnt: got %0d need %0d", n_o_pkt_cnt, cnt0 + 16'd1); end
    tests++; if (n_o_busy !== 1'b0 || n_o_tvalid !== 1'b0) begin fails++; $display("FAIL nh_idle: busy=%b tvalid=%b need 0 0", n_o_busy, n_o_tvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_body();
    int d;
    clear_chans();
    add_pkt(3, 20);
    drive();
    for (int i = 0; i < 18; i++) cyc();
    tests++;
    if (o_busy !== 1'b1 || o_tvalid !== 1'b1 || i_tready !== 4'b1000) begin
      fails++;
      $display("FAIL mid_body_pre: busy=%b tvalid=%b tready=%b need 1 1 1000", o_busy, o_tvalid, i_tready);
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL async_tvalid: got %b need 0", o_tvalid); end
    tests++; if (i_tready !== 4'b0) begin fails++; $display("FAIL async_tready: got %b need 0000", i_tready); end
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL async_busy: got %b need 0", o_busy); end
    tests++; if (o_pkt_cnt !== 16'd0) begin fails++; $display("FAIL async_pkt_cnt: got %0d need 0", o_pkt_cnt); end
    clear_chans();
    add_pkt(3, 3);
    add_pkt(0, 4);
    drive();
    m_grant = N - 1; m_pkts = 0; prev_busy = 0; gap_pend = 0; stall_pend = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    build_expected(1'b1);
    run(200, "post_rst");
    d = first_diff(obs_q, exp_q);
    tests++; if (d != -1) begin fails++; $display("FAIL post_rst_stream: first diff at %0d, got %0d need %0d", d, obs_q.size(), exp_q.size()); end
    tests++;
    if (gnt_obs.size() == 0 || gnt_obs[0] !== 9'd0) begin
      fails++;
      $display("FAIL post_rst_first_grant: got %0d grants, first %0d, need 0", gnt_obs.size(), (gnt_obs.size() > 0) ? gnt_obs[0] : 9'h1FF);
    end
    tests++; if (o_pkt_cnt !== 16'd2) begin fails++; $display("FAIL post_rst_pkt_cnt: got %0d need 2", o_pkt_cnt); end
  endtask

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_throttle();
    test_noheader();
    test_reset_mid_body();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lzma_stream_arbiter.md
# lzma_stream_arbiter

Packet-level round-robin arbiter that merges the byte-wide AXI-stream outputs of N LZMA compressor cores onto one shared output stream, which feeds the file/host sink. Each granted packet is optionally prefixed with the fixed 13-byte LZMA header: 5E 00 00 02 00 FF FF FF FF FF FF FF FF. The grant is held from the first byte to the tlast byte, so packets from different cores never interleave.

## Interface
- N, 4, number of requester channels (2..8); IW = $clog2(N)
- HEADER_EN, 1, 1 = insert the 13-byte header before every packet; 0 = pass-through only
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- i_tvalid  input  N  per-channel valid
- i_tready  output  N  per-channel ready
- i_tdata  input  8*N  channel c occupies bits [8c+7:8c]
- i_tlast  input  N  per-channel end of packet
- o_tvalid  output  1  merged stream valid
- o_tready  input  1  merged stream ready
- o_tdata  output  8  merged stream byte
- o_tlast  output  1  merged stream end of packet; never asserted on header bytes
- o_grant  output  IW  channel currently or last granted
- o_busy  output  1  high in HEADER or BODY
- o_pkt_cnt  output  16  count of completed packets, wraps 0xFFFF -> 0x0000

## Operation
- States: IDLE, HEADER, BODY. Reset -> IDLE, header index 0, o_grant = N-1 (so channel 0 wins first), o_pkt_cnt 0.
- IDLE: o_tvalid 0, i_tready all 0, o_busy 0. If any i_tvalid is high, pick the first asserted channel searching from (o_grant+1) mod N upward with wrap; register it into o_grant; next state HEADER if HEADER_EN else BODY. Otherwise stay.
- HEADER: o_tvalid 1, o_tdata = header[idx], o_tlast 0, all i_tready 0. idx advances on an o_tvalid&o_tready handshake. Handshake at idx 12 -> BODY, idx cleared to 0.
- BODY: combinational pass-through of the granted channel g: o_tvalid = i_tvalid[g], o_tdata = i_tdata[g], o_tlast = i_tlast[g], i_tready[g] = o_tready, all other i_tready 0. A handshake with i_tlast[g]=1 -> IDLE, o_pkt_cnt + 1 (mod 2^16).
- Requests from non-granted channels are ignored until IDLE; their tdata/tlast are never forwarded and their tready stays 0.
- The granted channel dropping i_tvalid mid-packet is legal: o_tvalid follows it and the state stays BODY.
- A 1-byte packet (tlast on the first byte) is legal: header (if enabled), one byte, then IDLE.
- Asserting rst mid-packet forces IDLE asynchronously: o_tvalid and all i_tready drop immediately, the partial packet is abandoned, and o_pkt_cnt clears.

## Timing
- Arbitration: request seen in IDLE at edge k -> o_tvalid high for the first byte (header or body) during cycle k+1.
- Header: exactly 13 handshakes; at o_tready=1 constantly, 13 cycles.
- Body: zero-latency pass-through, one byte per cycle at full throughput.
- Inter-packet gap: exactly one IDLE cycle after every tlast handshake, even when requests are continuously pending.
- o_grant changes only on the IDLE -> HEADER/BODY transition; o_pkt_cnt changes on the edge that completes the tlast handshake.
- Output back-pressure: o_tdata is held stable while o_tvalid=1 and o_tready=0 (header index frozen; body stability is the source's AXI obligation).

## Test plan
- Reset: rst high -> o_tvalid 0, i_tready 0, o_busy 0, o_grant N-1, o_pkt_cnt 0; release, no requests -> stays IDLE.
- Single packet, HEADER_EN=1, ch2 sends AA BB CC (tlast on CC), o_tready=1 -> output 5E 00 00 02 00, 8×FF, AA BB CC with tlast only on CC; o_pkt_cnt=1; o_grant=2.
- All 4 channels request continuously, 2-byte packets -> grant order 0,1,2,3,0; one idle cycle between packets; no interleaved bytes.
- Random o_tready throttling in header and body -> byte sequence is identical to the unthrottled run; o_tdata is stable while stalled.
- HEADER_EN=0, ch1 1-byte packet 7E with tlast -> output is the single byte 7E, tlast=1, o_pkt_cnt increments; arbitration request-to-valid latency is 1 cycle.
- rst pulsed mid-body on ch3 -> outputs drop asynchronously; after release ch0 is granted first and its packet is complete with a fresh header.
